prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/prefetch_unit.sv | 134 +++++++++++++
 tb/tb_prefetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants.
// Holds the prefetch FSM state enum and the per-instruction byte stride.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int FETCH_DATA_W = 32;
  localparam int INSTR_BYTES  = FETCH_DATA_W / 8;

  function automatic int instr_bytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: DEPTH x WIDTH ring buffer, extra pointer bit for full/empty.
// Ports: clk, rst_n, i_push, i_pop, i_clear, i_wdata, o_rdata, o_full, o_empty, o_count.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Head is forced to zero when empty so downstream never sees stale words.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_clear) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: credit-limited fetch, in-order response queue, jump flush.
// Ports: clock/reset, jump_flg/jump_target, imem_req_*, imem_rsp_*, out_valid/out_ready,
// instruction/address; align_err only when PREFETCH_ALIGN_CHK_EN is defined.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              jump_flg,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] address
`ifdef PREFETCH_ALIGN_CHK_EN
  ,
  output logic              align_err
`endif
);

  localparam int INC = instr_bytes(DATA_W);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);

  state_e            r_state;
  state_e            w_state_nx;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_drop_cnt;
  logic [CW-1:0]     w_inflight_nx;
  logic [CW-1:0]     w_drop_nx;
  logic [CW:0]       w_used;
  logic [ADDR_W-1:0] w_target;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_acc;
  logic              w_stale;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W+DATA_W-1:0] w_head;

`ifdef PREFETCH_ALIGN_CHK_EN
  logic w_mis;
  assign w_mis    = |(jump_target & LOW_MASK);
  assign w_target = jump_target & ~LOW_MASK;
`else
  assign w_target = jump_target;
`endif

  // Outstanding responses (stale ones included) plus queued words must
  // leave a free slot, so every response is guaranteed room on arrival.
  assign w_used = {1'b0, r_inflight} + {1'b0, w_count};
  assign imem_req_valid = reset & ~w_full &
                          (w_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_pc;

  assign w_acc   = imem_req_valid & imem_req_ready;
  assign w_stale = (r_drop_cnt != '0);
  assign w_push  = imem_rsp_valid & ~jump_flg & ~w_stale;
  assign w_pop   = out_valid & out_ready & ~jump_flg;

  assign w_inflight_nx = r_inflight + CW'(w_acc) - CW'(imem_rsp_valid);

  always_comb begin
    w_drop_nx  = r_drop_cnt;
    w_state_nx = r_state;
    if (jump_flg) begin
      // Everything still outstanding after this cycle is stale.
      w_drop_nx  = w_inflight_nx;
      w_state_nx = (w_inflight_nx != '0) ? FLUSH : RUN;
    end else begin
      if (imem_rsp_valid && w_stale) w_drop_nx = r_drop_cnt - 1'b1;
      if (r_state == FLUSH && w_drop_nx == '0) w_state_nx = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_inflight <= w_inflight_nx;
      r_drop_cnt <= w_drop_nx;
      if (jump_flg)   r_pc <= w_target;
      else if (w_acc) r_pc <= r_pc + ADDR_W'(INC);
      if (jump_flg)    r_rsp_pc <= w_target;
      else if (w_push) r_rsp_pc <= r_rsp_pc + ADDR_W'(INC);
    end
  end

`ifdef PREFETCH_ALIGN_CHK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                align_err <= 1'b0;
    else if (jump_flg & w_mis) align_err <= 1'b1;
  end
`endif

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (jump_flg),
    .i_wdata ({r_rsp_pc, imem_rsp_data}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid   = ~w_empty;
  assign instruction = w_head[DATA_W-1:0];
  assign address     = w_head[ADDR_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus random traffic
// against a program-order model; define PREFETCH_ALIGN_CHK_EN to test align_err.
module tb_prefetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        jump_flg;
  logic [31:0] jump_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] address;
`ifdef PREFETCH_ALIGN_CHK_EN
  logic        align_err;
`endif

  prefetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .jump_flg       (jump_flg),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction    (instruction),
    .address        (address)
`ifdef PREFETCH_ALIGN_CHK_EN
    ,
    .align_err      (align_err)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory model and expected program order.
  logic [31:0] pa[$];
  int          pd[$];
  int          last_due;
  int          cyc;
  int          lat_min, lat_max, rdy_pct, ordy_pct;
  logic        jmp_now;
  logic [31:0] jmp_tgt;
  logic [31:0] exp_pc, exp_addr;
  logic        prev_jump;
  logic        g_rsp, g_ov;
  logic [31:0] pop_addr[$];
  int          pop_cyc[$];
  logic [31:0] acc_addr[$];
  int          n_pops;

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef PREFETCH_ALIGN_CHK_EN
    return t & ~32'h3;
`else
    return t;
`endif
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (pop_addr.size() > i) ? pop_addr[i] : 32'hDEADDEAD;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (acc_addr.size() > i) ? acc_addr[i] : 32'hDEADDEAD;
  endfunction

  task automatic step();
    int lat, due;
    jump_flg       = jmp_now;
    jump_target    = jmp_tgt;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    out_ready      = ($urandom_range(99) < ordy_pct);
    if (pa.size() > 0 && pd[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pa[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clock);
    g_rsp = imem_rsp_valid;
    g_ov  = out_valid;
    if (prev_jump) chk("ov_after_jump", out_valid, 1'b0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      acc_addr.push_back(imem_req_addr);
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pa.push_back(imem_req_addr);
      pd.push_back(due);
      exp_pc = exp_pc + 32'd4;
    end
    if (out_valid && out_ready && !jump_flg) begin
      chk("out_addr", address, exp_addr);
      chk("out_instr", instruction, word_of(exp_addr));
      pop_addr.push_back(address);
      pop_cyc.push_back(cyc);
      n_pops++;
      exp_addr = exp_addr + 32'd4;
    end
    if (imem_rsp_valid) begin
      void'(pa.pop_front());
      void'(pd.pop_front());
    end
    if (jump_flg) begin
      exp_pc   = eff_target(jump_target);
      exp_addr = eff_target(jump_target);
    end
    prev_jump = jump_flg;
    @(posedge clock);
    #1;
    cyc++;
    jmp_now = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    jump_flg       = 1'b0;
    jump_target    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b1;
    jmp_now        = 1'b0;
    jmp_tgt        = '0;
    @(negedge clock);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_addr", address, 32'h0);
    chk("rst_pc", imem_req_addr, 32'h0);
    chk("rst_drop", dut.r_drop_cnt, 0);
`ifdef PREFETCH_ALIGN_CHK_EN
    chk("rst_align_err", align_err, 1'b0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;
    pa.delete();
    pd.delete();
    pop_addr.delete();
    pop_cyc.delete();
    acc_addr.delete();
    last_due  = -1;
    cyc       = 0;
    exp_pc    = 32'h0;
    exp_addr  = 32'h0;
    prev_jump = 1'b0;
  endtask

  initial begin
    n_pops = 0;
    reset  = 1'b0;

    // Streaming at latency 1: words on consecutive cycles after fill.
    lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 100;
    do_reset();
    run(8);
    chk("s1_a0", pop_at(0), 32'h0);
    chk("s1_a1", pop_at(1), 32'h4);
    chk("s1_a2", pop_at(2), 32'h8);
    chk("s1_c0", (pop_cyc.size() > 2) ? pop_cyc[0] : -1, 2);
    chk("s1_c1", (pop_cyc.size() > 2) ? pop_cyc[1] : -1, 3);
    chk("s1_c2", (pop_cyc.size() > 2) ? pop_cyc[2] : -1, 4);

    // Decode stalled: credit stops issue at DEPTH, nothing lost.
    ordy_pct = 0;
    do_reset();
    run(10);
    chk("s2_nreq", acc_addr.size(), 4);
    chk("s2_req_valid", imem_req_valid, 1'b0);
    chk("s2_out_valid", out_valid, 1'b1);
    ordy_pct = 100;
    run(6);
    chk("s2_a0", pop_at(0), 32'h0);
    chk("s2_a1", pop_at(1), 32'h4);
    chk("s2_a2", pop_at(2), 32'h8);
    chk("s2_a3", pop_at(3), 32'hC);

    // Jump with two requests in flight at latency 3.
    lat_min = 3; lat_max = 3;
    do_reset();
    run(2);
    rdy_pct = 0;
    jmp_now = 1'b1;
    jmp_tgt = 32'h100;
    step();
    chk("s3_drop_load", dut.r_drop_cnt, 2);
    rdy_pct = 100;
    run(12);
    chk("s3_first", pop_at(0), 32'h100);
    chk("s3_drop_done", dut.r_drop_cnt, 0);

    // Jump coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    run(6);
    jmp_now = 1'b1;
    jmp_tgt = 32'h200;
    pop_addr.delete();
    step();
    chk("s4_coincide", {g_rsp, g_ov}, 2'b11);
    chk("s4_empty", out_valid, 1'b0);
    run(8);
    chk("s4_first", pop_at(0), 32'h200);

    // PC wraps past the top of the address space.
    do_reset();
    run(2);
    jmp_now = 1'b1;
    jmp_tgt = 32'hFFFFFFFC;
    step();
    acc_addr.delete();
    run(3);
    chk("s5_top", acc_at(0), 32'hFFFFFFFC);
    chk("s5_wrap", acc_at(1), 32'h0);

`ifdef PREFETCH_ALIGN_CHK_EN
    // Misaligned target is rounded down and flagged stickily.
    do_reset();
    run(2);
    jmp_now = 1'b1;
    jmp_tgt = 32'h102;
    step();
    chk("s6_align_err", align_err, 1'b1);
    acc_addr.delete();
    run(2);
    chk("s6_addr", acc_at(0), 32'h100);
    jmp_now = 1'b1;
    jmp_tgt = 32'h300;
    step();
    run(2);
    chk("s6_sticky", align_err, 1'b1);
`endif

    // Random traffic with random latency, back-pressure and jumps.
    lat_min = 1; lat_max = 4; rdy_pct = 70; ordy_pct = 60;
    n_pops = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      if ($urandom_range(11) == 0) begin
        jmp_now = 1'b1;
        jmp_tgt = $urandom & ~32'h3;
      end
      step();
    end
    chk("rnd_progress", (n_pops > 100) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
